somador_serial_ctrl: RTL and testbench

Bit-serial addition controller. Sequences a single `somador_1bit` full-adder instance over the N bits of two operands, one bit per clock, LSB first. The carry is held in a register between bits. It accepts a one-cycle start request and returns the registered N-bit sum, carry-out and signed overflow with a one-cycle done pulse. It sits between the operand switches/registers and the 7-segment decoder path, and trades N cycles of latency for one adder cell.

---
 rtl/somador_serial_ctrl_if.sv | 25 ++
 rtl/somador_serial_ctrl.sv | 132 +++++++++++++
 tb/tb_somador_serial_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/somador_serial_ctrl_if.sv
// Start/operand/result bundle between the operand source and the serial adder controller.
// The master drives the request and operands; the slave returns the registered result and status.
interface somador_serial_ctrl_if #(
    parameter int N = 4
);
    logic         inicio;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         TE_in;
    logic [N-1:0] S;
    logic         TS;
    logic         ovf;
    logic         ocupado;
    logic         fim;

    modport master (
        output inicio, A, B, TE_in,
        input  S, TS, ovf, ocupado, fim
    );

    modport slave (
        input  inicio, A, B, TE_in,
        output S, TS, ovf, ocupado, fim
    );
endinterface

// File: rtl/somador_serial_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first, one bit per clock.
// The result, carry-out and signed overflow are published only when the last bit completes.
module somador_1bit (
    input  logic x,
    input  logic y,
    input  logic te,
    output logic s,
    output logic ts
);
    assign s  = x ^ y ^ te;
    assign ts = (x & y) | (te & (x ^ y));
endmodule

module somador_serial_ctrl #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    somador_serial_ctrl_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        SOMA   = 2'd1,
        FIM    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  r_sh;
    logic [N-1:0]  r_nx;
    logic [N-1:0]  s_q;
    logic          carry;
    logic          ts_q;
    logic          ovf_q;
    logic [CW-1:0] cnt;
    logic          cell_s;
    logic          cell_ts;
    logic          last;
    logic          ocupado;
    logic          fim;

    somador_1bit u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .te (carry),
        .s  (cell_s),
        .ts (cell_ts)
    );

    assign last = (cnt == CW'(N - 1));
    // Shift form works for N=1, where a concatenation with r_sh[N-1:1] would not.
    assign r_nx = (r_sh >> 1) | (N'(cell_s) << (N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCIOSO;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            OCIOSO:  if (bus.inicio) state_nx = SOMA;
            SOMA:    if (last) state_nx = FIM;
            FIM:     state_nx = OCIOSO;
            default: state_nx = OCIOSO;
        endcase
    end

    always_comb begin
        ocupado = 1'b0;
        fim     = 1'b0;
        case (state)
            SOMA:    ocupado = 1'b1;
            FIM: begin
                ocupado = 1'b1;
                fim     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s_q   <= '0;
            ts_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                OCIOSO: begin
                    if (bus.inicio) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        carry <= bus.TE_in;
                        cnt   <= '0;
                    end
                end
                SOMA: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_nx;
                    carry <= cell_ts;
                    cnt   <= cnt + CW'(1);
                    // carry still holds the carry into the MSB on the last edge
                    if (last) begin
                        s_q   <= r_nx;
                        ts_q  <= cell_ts;
                        ovf_q <= carry ^ cell_ts;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.S       = s_q;
    assign bus.TS      = ts_q;
    assign bus.ovf     = ovf_q;
    assign bus.ocupado = ocupado;
    assign bus.fim     = fim;
endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Scoreboard bench for the serial adder: accepted starts push an arithmetic reference result,
// a monitor checks fim/ocupado timing and the held result every cycle.
module tb_somador_serial_ctrl;
    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] s;
        logic         ts;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   c_acc = -1000;
    int   next_free = 0;
    exp_t q[$];
    exp_t held = '0;

    somador_serial_ctrl_if #(.N(N)) bus ();

    somador_serial_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    function automatic exp_t ref_add(input int a, input int b, input int te);
        exp_t e;
        int   u, sa, sb, ss;
        u  = a + b + te;
        sa = (a >= 2 ** (N - 1)) ? a - 2 ** N : a;
        sb = (b >= 2 ** (N - 1)) ? b - 2 ** N : b;
        ss = sa + sb + te;
        e.s   = N'(u % (2 ** N));
        e.ts  = (u >= 2 ** N);
        e.ovf = (ss > 2 ** (N - 1) - 1) || (ss < -(2 ** (N - 1)));
        return e;
    endfunction

    task automatic drive(input logic st, input logic [N-1:0] a, input logic [N-1:0] b, input logic te);
        @(negedge clk);
        bus.inicio = st;
        bus.A      = a;
        bus.B      = b;
        bus.TE_in  = te;
        if (st && rst_n && (cyc + 1) >= next_free) begin
            q.push_back(ref_add(int'(a), int'(b), int'(te)));
            c_acc     = cyc + 1;
            next_free = cyc + 1 + N + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        c_acc     = -1000;
        next_free = 0;
    endtask

    // Monitor: expected fim/ocupado come from the last accepted start edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                held = '0;
                chk("rst_S", int'(bus.S), 0);
                chk("rst_TS", int'(bus.TS), 0);
                chk("rst_ovf", int'(bus.ovf), 0);
                chk("rst_ocupado", int'(bus.ocupado), 0);
                chk("rst_fim", int'(bus.fim), 0);
            end else begin
                logic exp_fim, exp_busy;
                exp_fim  = (cyc == c_acc + N);
                exp_busy = (cyc >= c_acc) && (cyc <= c_acc + N);
                if (exp_fim) begin
                    if (q.size() == 0) begin
                        chk("scoreboard_underflow", 1, 0);
                    end else begin
                        held = q.pop_front();
                    end
                end
                chk("fim", int'(bus.fim), int'(exp_fim));
                chk("ocupado", int'(bus.ocupado), int'(exp_busy));
                chk("S", int'(bus.S), int'(held.s));
                chk("TS", int'(bus.TS), int'(held.ts));
                chk("ovf", int'(bus.ovf), int'(held.ovf));
            end
        end
    end

    initial begin
        bus.inicio = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.TE_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // directed sums: basic, wrap, carry-in
        drive(1'b1, 4'd3, 4'd5, 1'b0);   idle(N + 3);
        drive(1'b1, 4'd15, 4'd1, 1'b0);  idle(N + 3);
        drive(1'b1, 4'd15, 4'd15, 1'b1); idle(N + 3);
        drive(1'b1, 4'd0, 4'd0, 1'b1);   idle(N + 3);

        // start pulse during the second SOMA cycle must be ignored
        drive(1'b1, 4'd2, 4'd2, 1'b0);
        drive(1'b0, 4'd2, 4'd2, 1'b0);
        drive(1'b1, 4'd9, 4'd2, 1'b0);
        idle(N + 6);

        // reset during the third SOMA cycle
        drive(1'b1, 4'd11, 4'd7, 1'b1);
        idle(2);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_S", int'(bus.S), 0);
        chk("abort_TS", int'(bus.TS), 0);
        chk("abort_ovf", int'(bus.ovf), 0);
        chk("abort_ocupado", int'(bus.ocupado), 0);
        chk("abort_fim", int'(bus.fim), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'd6, 4'd7, 1'b0);
        idle(N + 3);

        // inicio held high: restart every N+2 cycles
        for (int i = 0; i < 20; i++) drive(1'b1, 4'd1, 4'd2, 1'b0);
        idle(N + 3);

        // random traffic, starts often arriving while busy
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, N'($urandom), N'($urandom), 1'($urandom));
        end
        idle(N + 3);
        chk("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
